arm_muldiv: RTL and testbench
=============================

Name: arm_muldiv

Overview:
Parametrised iterative multiply/divide unit that extends the ARM datapath with MUL, MLA, UDIV and SDIV. It sits beside the ALU. The controller stalls PC update while busy is high, and the writeback mux takes result when done pulses. Operand width is a parameter. Each operation runs over multiple cycles through a start/busy/done handshake. The unit also produces N/Z flags for the existing flag register (FlagW[1] path only; C and V are untouched).

Parameters:
WIDTH, 32, operand and result width in bits (minimum 4)
CNTW, $clog2(WIDTH+1), iteration counter width (derived; not to be overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset=0 resets the block)
start  input  1  request; sampled on rising clk, accepted only in IDLE or DONE
op  input  2  00 MUL, 01 MLA, 10 UDIV, 11 SDIV; captured on accept
a  input  WIDTH  multiplicand / dividend (Rn); captured on accept
b  input  WIDTH  multiplier / divisor (Rm); captured on accept
acc  input  WIDTH  MLA addend (Ra); captured on accept, ignored otherwise
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result, flags and div_by_zero are valid from this cycle on
result  output  WIDTH  low WIDTH bits of product (MUL/MLA) or quotient (UDIV/SDIV)
flags_nz  output  2  {N,Z}: N=result[WIDTH-1], Z=(result==0)
div_by_zero  output  1  set when a divide completes with b==0; cleared on next accept

Behaviour:
- Reset (async, reset=0): state=IDLE; busy=0, done=0, result=0, flags_nz=2'b01, div_by_zero=0. Counter and internal registers are cleared.
- States:
  - IDLE: no operation pending.
  - RUN: iterating.
  - DONE: single cycle, then returns to IDLE.
- Accept: start=1 at a rising edge while in IDLE or DONE. Operands and op are latched, div_by_zero is cleared, state becomes RUN, counter is loaded with WIDTH.
  - Exception: op[1]=1 and b==0 goes straight to DONE.
- start while in RUN is ignored. No queueing. Operands are not re-latched.
- RUN: one iteration per cycle, counter decrements. On the edge where counter reaches 0, state becomes DONE. Normal latency is therefore WIDTH+1 edges from the accepting edge to the edge that asserts done.
- busy=1 exactly while in RUN. done=1 exactly while in DONE. busy and done are never high together.
- DONE: result/flags_nz/div_by_zero are updated on entry and held stable until the next accept or reset. If start=1 during DONE, the new operation is accepted on that edge (back-to-back, no idle bubble).
- MUL: shift-add on an unsigned 2*WIDTH partial product. result = (a*b) mod 2^WIDTH, which is identical for signed operands.
- MLA: the product is computed as for MUL; on the final iteration acc is added. result = (a*b+acc) mod 2^WIDTH. Overflow is silently discarded.
- UDIV: restoring division, one quotient bit per cycle. result = floor(a/b). The remainder is not output.
- SDIV: operand magnitudes are divided unsigned. The quotient is negated if a[W-1]^b[W-1]. Truncation is toward zero.
  - -2^(W-1) / -1 = -2^(W-1) (wraps; no flag).
- Divide by zero (UDIV or SDIV, b==0): result=0, div_by_zero=1, flags_nz=2'b01. done is asserted one edge after accept (latency 1). RUN is bypassed.
- flags_nz is always derived from the registered result. It is not forced to zero for MUL/MLA.
- Reset asserted mid-RUN aborts the operation immediately. All outputs take their reset values and no done pulse is produced.
- Pure synchronous logic apart from the async reset. There are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=32. Reset, then MUL a=7, b=6, start held 1 cycle. Required:
  - busy high for 32 cycles.
  - done on the 33rd edge after accept.
  - result=42, flags_nz=00.
- MLA a=0xFFFFFFFF, b=2, acc=5 -> result=0x00000003, flags_nz=00. UDIV a=100, b=7 -> result=14. SDIV a=-100 (0xFFFFFF9C), b=7 -> result=0xFFFFFFF2 (-14), flags_nz=10.
- UDIV a=5, b=0 -> done one edge after accept, result=0, div_by_zero=1, flags_nz=01, busy never high. The next accept (MUL 3*3) clears div_by_zero; that MUL yields result=9.
- SDIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, flags_nz=10. MUL a=0x10000, b=0x10000 -> result=0, flags_nz=01.
- Handshake checks:
  - start pulsed mid-RUN with different operands is ignored and the original result is returned.
  - start asserted during the done cycle is accepted: busy is high on the next cycle and the second result is correct.
- Drive reset=0 at cycle 10 of a UDIV. Required:
  - busy/done/result drop to 0 asynchronously (before the next clk edge); flags_nz=01.
  - After release, no done appears until a new start.

Source files
------------

// File: rtl/arm_muldiv.sv
// Iterative MUL/MLA/UDIV/SDIV unit for the ARM datapath: start/busy/done handshake,
// one iteration per cycle, result plus N/Z flags for the flag register.
module arm_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags_nz,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] OP_MLA  = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b11;

    state_t               state;
    logic [CNTW-1:0]      cnt;
    logic [1:0]           op_r;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic                 neg;

    logic [2*WIDTH-1:0]   prod_nx;
    logic [WIDTH:0]       shift;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     rem_nx;
    logic [WIDTH-1:0]     quo_nx;
    logic [WIDTH-1:0]     mul_res;
    logic [WIDTH-1:0]     div_res;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 is_signed;

    // One shift-add step and one restoring-division step are evaluated every
    // RUN cycle; op_r only selects which one lands in result.
    always_comb begin
        prod_nx   = mplier[0] ? prod + mcand : prod;
        shift     = {rem, quo[WIDTH-1]};
        diff      = shift - {1'b0, divisor};
        rem_nx    = diff[WIDTH] ? shift[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx    = {quo[WIDTH-2:0], ~diff[WIDTH]};
        mul_res   = prod_nx[WIDTH-1:0] + ((op_r == OP_MLA) ? acc_r : '0);
        div_res   = neg ? -quo_nx : quo_nx;
        is_signed = (op == OP_SDIV);
        a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    assign flags_nz = {result[WIDTH-1], result == '0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_r        <= '0;
            mcand       <= '0;
            prod        <= '0;
            mplier      <= '0;
            acc_r       <= '0;
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            neg         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r        <= op;
                        div_by_zero <= 1'b0;
                        mcand       <= {{WIDTH{1'b0}}, a};
                        mplier      <= b;
                        prod        <= '0;
                        acc_r       <= acc;
                        rem         <= '0;
                        quo         <= a_mag;
                        divisor     <= b_mag;
                        neg         <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        if (op[1] && b == '0) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            result      <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            cnt   <= CNTW'(WIDTH);
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    cnt    <= cnt - CNTW'(1);
                    prod   <= prod_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    rem    <= rem_nx;
                    quo    <= quo_nx;
                    if (cnt == CNTW'(1)) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= op_r[1] ? div_res : mul_res;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_muldiv.sv
// Randomized self-checking bench for arm_muldiv against an arithmetic reference model.
module tb_arm_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] acc = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [1:0]   flags_nz;
    logic         div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    arm_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .acc         (acc),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .flags_nz    (flags_nz),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic [W-1:0] z);
        logic [63:0] p;
        longint      sx, sy, q;
        p = 64'(x) * 64'(y);
        case (o)
            2'b00: return p[W-1:0];
            2'b01: return p[W-1:0] + z;
            2'b10: return (y == 0) ? '0 : x / y;
            default: begin
                if (y == 0) return '0;
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                q  = sx / sy;
                return q[W-1:0];
            end
        endcase
    endfunction

    // Called just after the accepting edge; returns edges (accept edge = 1) up to the
    // cycle where done is seen, and the number of sampled busy cycles. edges=0 on timeout.
    task automatic wait_done(output int edges, output int bc);
        edges = 1;
        bc    = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            if (busy && done) check("busy_done_overlap", 1, 0);
            if (done) return;
            if (busy) bc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        edges = 0;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z, input string tag, input bit b2b);
        logic [W-1:0] exp;
        bit           dz;
        int           edges, bc;
        exp = model(o, x, y, z);
        dz  = o[1] && (y == 0);
        if (!b2b) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; acc = z;
        @(posedge clk);
        wait_done(edges, bc);
        check({tag, ".latency"}, edges, dz ? 1 : W + 1);
        check({tag, ".busy"},    bc,    dz ? 0 : W);
        check({tag, ".result"},  result, exp);
        check({tag, ".flags"},   flags_nz, {exp[W-1], exp == 0});
        check({tag, ".dbz"},     div_by_zero, dz);
    endtask

    initial begin
        int edges, bc;
        bit seen;
        logic [1:0]   ro;
        logic [W-1:0] rx, ry, rz;

        #12;
        check("rst.busy",   busy, 0);
        check("rst.done",   done, 0);
        check("rst.result", result, 0);
        check("rst.flags",  flags_nz, 2'b01);
        check("rst.dbz",    div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        do_op(2'b00, 32'd7, 32'd6, 32'd0, "mul7x6", 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd5, "mla", 0);
        do_op(2'b10, 32'd100, 32'd7, 32'd0, "udiv", 0);
        do_op(2'b11, 32'hFFFF_FF9C, 32'd7, 32'd0, "sdiv_neg", 0);
        do_op(2'b10, 32'd5, 32'd0, 32'd0, "udiv_by0", 0);
        do_op(2'b00, 32'd3, 32'd3, 32'd0, "mul_after_dbz", 0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "sdiv_wrap", 0);
        do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, "mul_zero", 0);
        do_op(2'b11, 32'd9, 32'd0, 32'd0, "sdiv_by0", 0);

        // start pulsed mid-RUN must not disturb the operation in flight
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6; acc = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < W + 5; i++) begin
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        check("midrun.done",   seen, 1);
        check("midrun.result", result, 32'd42);

        // back-to-back: a new start in the done cycle is accepted without a bubble
        do_op(2'b00, 32'd12345, 32'd678, 32'd0, "b2b_first", 1);
        do_op(2'b10, 32'd1000, 32'd3, 32'd0, "b2b_second", 1);

        for (int t = 0; t < 40; t++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 5))
                0:       ry = '0;
                1:       ry = $urandom_range(1, 15);
                2:       ry = -$urandom_range(1, 15);
                default: ry = $urandom;
            endcase
            rz = $urandom;
            do_op(ro, rx, ry, rz, $sformatf("rnd%0d", t), 0);
        end

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'hFFFF_FFFF; b = 32'd3; acc = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_abort.busy", busy, 1);
        reset = 1'b0;
        #1;
        check("abort.busy",   busy, 0);
        check("abort.done",   done, 0);
        check("abort.result", result, 0);
        check("abort.flags",  flags_nz, 2'b01);
        check("abort.dbz",    div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("abort.no_done", seen, 0);

        do_op(2'b01, 32'd10, 32'd10, 32'd5, "post_abort_mla", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
